// File: rtl/ym_dbg_write.sv
// ym_dbg_write: serial debug-port receiver.
// Shifts in a DATA_WIDTH-bit word LSB first under the c1/c2 two-phase enables.
// The finished word is held on word_out with a valid/ack handshake.
// Optional even-parity trailer bit: define YM_DBG_WRITE_PARITY_EN.
module ym_dbg_write #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  MCLK,
   input  logic                  nreset,
   input  logic                  c1,
   input  logic                  c2,
   input  logic                  start,
   input  logic                  serial_in,
   input  logic                  word_ack,
   output logic [DATA_WIDTH-1:0] word_out,
   output logic                  word_valid,
   output logic                  busy,
   output logic                  overrun,
   output logic                  parity_err
);

   localparam int CW = $clog2(DATA_WIDTH + 2);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef YM_DBG_WRITE_PARITY_EN
      ST_PAR   = 2'd2,
`endif
      ST_SHIFT = 2'd1
   } state_t;

   // c1 has priority: an edge with both enables high is a c1 edge.
   logic c1_edge_s;
   logic c2_edge_s;
   assign c1_edge_s = c1;
   assign c2_edge_s = c2 & ~c1;

   state_t                state_q,      state_d;
   logic [DATA_WIDTH-1:0] shreg_m_q,    shreg_m_d;
   // Slave half keeps only the bits that feed back into the master;
   // bit 0 of the master is shifted out on the next capture and never reloads.
   logic [DATA_WIDTH-2:0] shreg_s_q,    shreg_s_d;
   logic [CW-1:0]         bitcnt_q,     bitcnt_d;
   logic                  pending_q,    pending_d;
   logic [DATA_WIDTH-1:0] word_out_q,   word_out_d;
   logic                  word_valid_q, word_valid_d;
   logic                  busy_q,       busy_d;
   logic                  overrun_q,    overrun_d;
   logic                  complete_s;
   logic                  ack_s;
`ifdef YM_DBG_WRITE_PARITY_EN
   logic                  par_bit_q,    par_bit_d;
   logic                  parity_err_q, parity_err_d;
`endif

   assign ack_s = word_ack & word_valid_q;

   // Next-state, shift, completion and handshake logic.
   always_comb begin
      state_d      = state_q;
      shreg_m_d    = shreg_m_q;
      shreg_s_d    = shreg_s_q;
      bitcnt_d     = bitcnt_q;
      pending_d    = pending_q;
      word_out_d   = word_out_q;
      word_valid_d = word_valid_q;
      busy_d       = busy_q;
      overrun_d    = overrun_q;
      complete_s   = 1'b0;
`ifdef YM_DBG_WRITE_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = parity_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (c1_edge_s && start) begin
               state_d   = ST_SHIFT;
               busy_d    = 1'b1;
               bitcnt_d  = '0;
               pending_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (c1_edge_s) begin
               shreg_m_d = {serial_in, shreg_s_q};
               pending_d = 1'b1;
            end else if (c2_edge_s && pending_q) begin
               shreg_s_d = shreg_m_q[DATA_WIDTH-1:1];
               bitcnt_d  = bitcnt_q + CNT_ONE;
               pending_d = 1'b0;
               if (bitcnt_q == LAST_BIT) begin
`ifdef YM_DBG_WRITE_PARITY_EN
                  state_d = ST_PAR;
`else
                  complete_s = 1'b1;
`endif
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
`ifdef YM_DBG_WRITE_PARITY_EN
         ST_PAR: begin
            if (c1_edge_s) begin
               par_bit_d = serial_in;
               pending_d = 1'b1;
            end else if (c2_edge_s && pending_q) begin
               pending_d = 1'b0;
               if ((^{shreg_m_q, par_bit_q}) == 1'b0) begin
                  complete_s = 1'b1;
               end else begin
                  parity_err_d = 1'b1;
                  state_d      = ST_IDLE;
                  busy_d       = 1'b0;
               end
            end else begin
               state_d = ST_PAR;
            end
         end
`endif
         default: begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            pending_d = 1'b0;
         end
      endcase

      // A new word always lands; overrun reflects whether the old one was lost.
      if (complete_s) begin
         word_out_d   = shreg_m_q;
         word_valid_d = 1'b1;
         busy_d       = 1'b0;
         state_d      = ST_IDLE;
         if (word_valid_q && !word_ack) begin
            overrun_d = 1'b1;
         end else if (ack_s) begin
            overrun_d = 1'b0;
         end else begin
            overrun_d = overrun_q;
         end
      end else if (ack_s) begin
         word_valid_d = 1'b0;
         overrun_d    = 1'b0;
      end else begin
         word_valid_d = word_valid_q;
      end
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge MCLK or negedge nreset) begin
      if (!nreset) begin
         state_q      <= ST_IDLE;
         shreg_m_q    <= '0;
         shreg_s_q    <= '0;
         bitcnt_q     <= '0;
         pending_q    <= 1'b0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_m_q    <= shreg_m_d;
         shreg_s_q    <= shreg_s_d;
         bitcnt_q     <= bitcnt_d;
         pending_q    <= pending_d;
         word_out_q   <= word_out_d;
         word_valid_q <= word_valid_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef YM_DBG_WRITE_PARITY_EN
   // Parity trailer bit and sticky parity error flag.
   always_ff @(posedge MCLK or negedge nreset) begin
      if (!nreset) begin
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bit_q    <= par_bit_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign word_out   = word_out_q;
   assign word_valid = word_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_ym_dbg_write.sv
// Testbench for ym_dbg_write: directed frames plus randomized edges,
// checked against a bit-list reference model.
module tb_ym_dbg_write;

   localparam int W = 8;
`ifdef YM_DBG_WRITE_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic         MCLK = 1'b0;
   logic         nreset;
   logic         c1, c2, start, serial_in, word_ack;
   logic [W-1:0] word_out;
   logic         word_valid, busy, overrun, parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit           m_busy, m_pend, m_pbit, m_inpar;
   int           m_nbits;
   logic [W-1:0] m_word, m_out;
   bit           m_valid, m_overrun, m_perr;

   ym_dbg_write #(.DATA_WIDTH(W)) dut (
      .MCLK(MCLK), .nreset(nreset), .c1(c1), .c2(c2), .start(start),
      .serial_in(serial_in), .word_ack(word_ack), .word_out(word_out),
      .word_valid(word_valid), .busy(busy), .overrun(overrun),
      .parity_err(parity_err)
   );

   // free-running master clock
   always #5 MCLK = ~MCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".word_out"},   32'(word_out),   32'(m_out));
      check_eq({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
      check_eq({tag, ".busy"},       32'(busy),       32'(m_busy));
      check_eq({tag, ".overrun"},    32'(overrun),    32'(m_overrun));
      check_eq({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
   endtask

   task automatic model_reset();
      m_busy = 0; m_pend = 0; m_pbit = 0; m_inpar = 0; m_nbits = 0;
      m_word = '0; m_out = '0; m_valid = 0; m_overrun = 0; m_perr = 0;
   endtask

   // One MCLK edge: drive inputs, advance the model, check on the falling edge.
   task automatic do_edge(input logic i_c1, input logic i_c2, input logic i_start,
                          input logic i_sin, input logic i_ack, input string tag);
      bit complete;
      bit ack_eff;
      c1 = i_c1; c2 = i_c2; start = i_start; serial_in = i_sin; word_ack = i_ack;
      complete = 0;
      ack_eff  = i_ack && m_valid;
      if (i_c1) begin
         if (!m_busy) begin
            if (i_start) begin
               m_busy = 1; m_nbits = 0; m_pend = 0; m_inpar = 0;
            end
         end else begin
            m_pend = 1; m_pbit = i_sin;
         end
      end else if (i_c2 && m_busy && m_pend) begin
         m_pend = 0;
         if (!m_inpar) begin
            m_word[m_nbits] = m_pbit;
            m_nbits++;
            if (m_nbits == W) begin
               if (PAR_EN) m_inpar = 1;
               else        complete = 1;
            end
         end else begin
            if ((($countones(m_word) + int'(m_pbit)) % 2) == 0) complete = 1;
            else begin
               m_perr = 1; m_busy = 0;
            end
         end
      end
      if (complete) begin
         m_out  = m_word;
         m_busy = 0;
         if (m_valid && !i_ack) m_overrun = 1;
         else if (ack_eff)      m_overrun = 0;
         m_valid = 1;
      end else if (ack_eff) begin
         m_valid = 0; m_overrun = 0;
      end
      @(posedge MCLK);
      @(negedge MCLK);
      check_all(tag);
   endtask

   // Full frame: start edge, W bits as c1/c2 pairs, optional parity trailer.
   task automatic send_frame(input logic [W-1:0] data, input logic par,
                             input logic ack_last, input string tag);
      do_edge(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {tag, ".start"});
      for (int i = 0; i < W; i++) begin
         do_edge(1'b1, 1'b0, 1'b0, data[i], 1'b0, {tag, ".c1"});
         do_edge(1'b0, 1'b1, 1'b0, 1'b0,
                 (i == W - 1 && !PAR_EN) ? ack_last : 1'b0, {tag, ".c2"});
      end
      if (PAR_EN) begin
         do_edge(1'b1, 1'b0, 1'b0, par, 1'b0, {tag, ".pc1"});
         do_edge(1'b0, 1'b1, 1'b0, 1'b0, ack_last, {tag, ".pc2"});
      end
   endtask

   initial begin
      logic [W-1:0] d;
      nreset = 1'b0; c1 = 0; c2 = 0; start = 0; serial_in = 0; word_ack = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge MCLK);
      nreset = 1'b1;

      // 0xA5: basic frame
      d = 8'hA5;
      send_frame(d, ^d, 1'b0, "a5");
      check_eq("a5.word", 32'(word_out), 32'h0000_00A5);
      check_eq("a5.valid", 32'(word_valid), 32'd1);

      // 0x3C without ack: overrun, then ack clears valid and overrun
      d = 8'h3C;
      send_frame(d, ^d, 1'b0, "3c");
      check_eq("3c.overrun", 32'(overrun), 32'd1);
      check_eq("3c.word", 32'(word_out), 32'h0000_003C);
      do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ack");
      check_eq("ack.valid", 32'(word_valid), 32'd0);

      // 0x5A with ack on the completing edge
      d = 8'h5A;
      send_frame(d, ^d, 1'b1, "5a");
      check_eq("5a.valid", 32'(word_valid), 32'd1);
      check_eq("5a.overrun", 32'(overrun), 32'd0);
      do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ack2");

      // 0x96 with a stray start after 3 bits and c2 edges without a capture
      d = 8'h96;
      do_edge(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "st.start");
      do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "st.c2x");
      for (int i = 0; i < W; i++) begin
         do_edge(1'b1, 1'b0, (i == 3) ? 1'b1 : 1'b0, d[i], 1'b0, "st.c1");
         do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "st.c2");
         if (i == 3) do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "st.c2x");
      end
      if (PAR_EN) begin
         do_edge(1'b1, 1'b1, 1'b0, ^d, 1'b0, "st.pc1");
         do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "st.pc2");
      end
      check_eq("st.word", 32'(word_out), 32'h0000_0096);
      do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ack3");

      // reset mid-frame after 4 bits, then 0xFF
      d = 8'h0F;
      do_edge(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rs.start");
      for (int i = 0; i < 4; i++) begin
         do_edge(1'b1, 1'b0, 1'b0, d[i], 1'b0, "rs.c1");
         do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rs.c2");
      end
      #2 nreset = 1'b0;
      model_reset();
      #1;
      check_all("rs.inreset");
      @(negedge MCLK);
      nreset = 1'b1;
      d = 8'hFF;
      send_frame(d, ^d, 1'b0, "ff");
      check_eq("ff.word", 32'(word_out), 32'h0000_00FF);
      check_eq("ff.overrun", 32'(overrun), 32'd0);
      do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ack4");

      if (PAR_EN) begin
         d = 8'h01;
         send_frame(d, 1'b1, 1'b0, "p01");
         check_eq("p01.word", 32'(word_out), 32'h0000_0001);
         check_eq("p01.perr", 32'(parity_err), 32'd0);
         d = 8'h03;
         send_frame(d, 1'b1, 1'b0, "p03");
         check_eq("p03.word", 32'(word_out), 32'h0000_0001);
         check_eq("p03.perr", 32'(parity_err), 32'd1);
         check_eq("p03.busy", 32'(busy), 32'd0);
      end

      // random well-formed frames with random gaps and acks
      for (int f = 0; f < 30; f++) begin
         d = W'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++)
            do_edge(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                    1'($urandom_range(0, 1)), "rf.gap");
         send_frame(d, (^d) ^ ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rf");
      end

      // fully random edges
      for (int k = 0; k < 600; k++) begin
         do_edge(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ym_dbg_write.md
Name: ym_dbg_write

Overview:
- Serial debug/test-port receiver: the write-direction counterpart of the debug readout chain, which parallel-loads and shifts out LSB first.
- Captures a DATA_WIDTH-bit word shifted in LSB first under the c1/c2 two-phase enables used throughout the chip cells.
- Presents the word on a parallel holding register with a valid/ack handshake.
- Sits between the test pin logic and internal debug registers of ym3438/ym7101 cores.

Parameters:
DATA_WIDTH, 8, word length in bits (>=2)

Ports:
MCLK  input  1  master clock; all state updates on posedge
nreset  input  1  asynchronous active-low reset
c1  input  1  phase-1 enable; samples serial_in and start
c2  input  1  phase-2 enable; master-to-slave transfer and bit count
start  input  1  begin frame; sampled on a c1 edge while idle
serial_in  input  1  serial data, LSB first
word_ack  input  1  consumer acknowledge; sampled on any MCLK edge
word_out  output  DATA_WIDTH  last completed word
word_valid  output  1  word_out holds an unacknowledged word
busy  output  1  frame in progress
overrun  output  1  sticky: word completed while word_valid was already 1
parity_err  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (nreset=0, asynchronous): state IDLE. shreg_m=0, shreg_s=0, bitcnt=0, word_out=0, word_valid=0, busy=0, overrun=0, parity_err=0. Asserting reset mid-frame discards the partial word immediately.
- Phase rule: an edge with c1=1 is a c1 edge, regardless of c2; c2 is ignored when c1=1. An edge with c2=1 and c1=0 is a c2 edge.
- States: IDLE, SHIFT, PAR. PAR exists only with the feature enabled.
- IDLE: on a c1 edge with start=1, go to SHIFT, busy<=1, bitcnt<=0. serial_in is not sampled on this edge. start is ignored outside IDLE.
- SHIFT, c1 edge: shreg_m <= {serial_in, shreg_s[DATA_WIDTH-1:1]}; set the internal pending flag.
- SHIFT, c2 edge with pending=1: shreg_s <= shreg_m; bitcnt++; clear pending. A c2 edge without a preceding c1 capture does nothing.
- Completion, without the feature: on the c2 edge where bitcnt reaches DATA_WIDTH:
  - word_out <= shreg_m
  - word_valid <= 1
  - busy <= 0
  - state <= IDLE
  - Latency: word_valid rises on the same MCLK edge that transfers bit DATA_WIDTH-1.
- Handshake: word_ack=1 with word_valid=1 clears word_valid and overrun on that edge. word_ack with word_valid=0 has no effect.
- Completion while word_valid=1 and no ack on that edge: word_out is overwritten with the new word, word_valid stays 1, overrun<=1.
- Completion on the same edge as word_ack: word_out takes the new word, word_valid stays 1, overrun<=0.
- bitcnt width: $clog2(DATA_WIDTH+2) bits. It never wraps because it is cleared on start.
- A new start is accepted on the first c1 edge after returning to IDLE. Back-to-back frames need no gap cycle beyond that.

Optional Feature:
YM_DBG_WRITE_PARITY_EN
- Defined:
  - After bit DATA_WIDTH-1, state goes to PAR instead of completing.
  - The next c1 edge samples the parity bit; the following c2 edge checks even parity over data and parity bits.
  - Match: normal completion.
  - Mismatch: word discarded (word_out and word_valid unchanged), parity_err<=1, state IDLE, busy<=0.
  - parity_err is cleared only by nreset.
- Undefined: no PAR state, no parity bit; parity_err tied to 0.

Test Plan:
- DATA_WIDTH=8, start, then send 0xA5 LSB first (1,0,1,0,0,1,0,1), one c1 then one c2 per bit -> word_out=0xA5, word_valid=1 on the 8th c2 edge, busy=0, overrun=0.
- After 0xA5, hold word_ack=0 and send 0x3C -> word_out=0x3C, word_valid=1, overrun=1. Then pulse word_ack -> word_valid=0, overrun=0.
- Pulse word_ack on the same edge as the 8th c2 of 0x5A -> word_out=0x5A, word_valid=1, overrun=0.
- Pulse start again after 3 bits, plus extra c2 edges with no c1 -> ignored; bitcnt advances only on paired c1/c2; received word is still correct.
- Drop nreset after 4 bits, release, then send 0xFF -> all outputs 0 during reset; word_out=0xFF afterwards with no residue from the partial frame.
- Feature on: send 0x01 with parity bit 1 -> word_out=0x01, valid. Send 0x03 with parity bit 1 -> word_valid unchanged, parity_err=1, busy=0.
